// File: rtl/backprop_delta_if.sv
// Bundles the backward-pass request/response signals between the training controller and backprop_delta.
// The controller drives start and the data snapshot; the delta engine answers with busy/done and the deltas.
interface backprop_delta_if #(
    parameter int DWIDTH = 32
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic signed [DWIDTH-1:0] t1, t2, o1, o2, h1, h2, h3;
    logic signed [DWIDTH-1:0] wa1, wa2, wb1, wb2, wc1, wc2;
    logic signed [DWIDTH-1:0] delta_o1, delta_o2, delta_h1, delta_h2, delta_h3;

    modport master (
        output start, t1, t2, o1, o2, h1, h2, h3, wa1, wa2, wb1, wb2, wc1, wc2,
        input  busy, done, delta_o1, delta_o2, delta_h1, delta_h2, delta_h3
    );

    modport slave (
        input  start, t1, t2, o1, o2, h1, h2, h3, wa1, wa2, wb1, wb2, wc1, wc2,
        output busy, done, delta_o1, delta_o2, delta_h1, delta_h2, delta_h3
    );
endinterface

// File: rtl/backprop_delta.sv
// Error deltas for the 2-3-2 network using one shared saturating fixed-point multiplier.
// Latency: start accepted at edge N -> busy cycles N+1..N+16, done pulse in cycle N+17.
module backprop_delta #(
    parameter int DWIDTH = 32,
    parameter int frac   = 24
) (
    input  logic            clk,
    input  logic            rst,
    backprop_delta_if.slave bus
);
    typedef logic signed [DWIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam word_t ONE  = word_t'(1) << frac;
    localparam word_t WMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam word_t WMIN = {1'b1, {(DWIDTH-1){1'b0}}};

    function automatic word_t sat_w(input logic [DWIDTH:0] x);
        if (x[DWIDTH] != x[DWIDTH-1]) return x[DWIDTH] ? WMIN : WMAX;
        return x[DWIDTH-1:0];
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        return sat_w({a[DWIDTH-1], a} + {b[DWIDTH-1], b});
    endfunction

    function automatic word_t sat_sub(input word_t a, input word_t b);
        return sat_w({a[DWIDTH-1], a} - {b[DWIDTH-1], b});
    endfunction

    // Low 2*DWIDTH bits of the sign-extended product are the exact signed product.
    function automatic word_t mul_q(input word_t a, input word_t b);
        logic signed [2*DWIDTH-1:0] p;
        p = {{DWIDTH{a[DWIDTH-1]}}, a} * {{DWIDTH{b[DWIDTH-1]}}, b};
        p = p >>> frac;
        if (p[2*DWIDTH-1:DWIDTH-1] != {(DWIDTH+1){p[2*DWIDTH-1]}})
            return p[2*DWIDTH-1] ? WMIN : WMAX;
        return p[DWIDTH-1:0];
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    word_t       t_q[2], t_d[2], o_q[2], o_d[2];
    word_t       h_q[3], h_d[3];
    word_t       w_q[3][2], w_d[3][2];
    word_t       tmp_q, tmp_d, acc_q, acc_d;
    word_t       dlo_q[2], dlo_d[2], dh_q[3], dh_d[3];
    word_t       out_o_q[2], out_o_d[2], out_h_q[3], out_h_d[3];

    word_t       mul_a, mul_b, mul_p;
    logic        k;
    logic [1:0]  hj;

    assign k     = step_q[1];
    assign hj    = step_q[3:2] - 2'd1;
    assign mul_p = mul_q(mul_a, mul_b);

    // Steps 0..3 handle the output neurons, then four steps per hidden neuron.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (step_q < 4'd4) begin
            if (!step_q[0]) begin
                mul_a = o_q[k];
                mul_b = sat_sub(ONE, o_q[k]);
            end else begin
                mul_a = sat_sub(t_q[k], o_q[k]);
                mul_b = tmp_q;
            end
        end else begin
            case (step_q[1:0])
                2'd0: begin mul_a = dlo_q[0]; mul_b = w_q[hj][0]; end
                2'd1: begin mul_a = dlo_q[1]; mul_b = w_q[hj][1]; end
                2'd2: begin mul_a = h_q[hj];  mul_b = sat_sub(ONE, h_q[hj]); end
                default: begin mul_a = acc_q; mul_b = tmp_q; end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        t_d     = t_q;
        o_d     = o_q;
        h_d     = h_q;
        w_d     = w_q;
        tmp_d   = tmp_q;
        acc_d   = acc_q;
        dlo_d   = dlo_q;
        dh_d    = dh_q;
        out_o_d = out_o_q;
        out_h_d = out_h_q;
        case (state_q)
            RUN: begin
                step_d = step_q + 4'd1;
                if (step_q < 4'd4) begin
                    if (!step_q[0]) tmp_d    = mul_p;
                    else            dlo_d[k] = mul_p;
                end else begin
                    case (step_q[1:0])
                        2'd0:    tmp_d    = mul_p;
                        2'd1:    acc_d    = sat_add(tmp_q, mul_p);
                        2'd2:    tmp_d    = mul_p;
                        default: dh_d[hj] = mul_p;
                    endcase
                end
                if (step_q == 4'd15) begin
                    state_d = DONE;
                    out_o_d = dlo_d;
                    out_h_d = dh_d;
                end
            end
            default: begin
                // The edge that ends the done cycle may already accept the next pass.
                if (state_q == DONE) state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    step_d  = 4'd0;
                    t_d     = '{bus.t1, bus.t2};
                    o_d     = '{bus.o1, bus.o2};
                    h_d     = '{bus.h1, bus.h2, bus.h3};
                    w_d     = '{'{bus.wa1, bus.wa2}, '{bus.wb1, bus.wb2}, '{bus.wc1, bus.wc2}};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            t_q     <= '{default: '0};
            o_q     <= '{default: '0};
            h_q     <= '{default: '0};
            w_q     <= '{default: '{default: '0}};
            tmp_q   <= '0;
            acc_q   <= '0;
            dlo_q   <= '{default: '0};
            dh_q    <= '{default: '0};
            out_o_q <= '{default: '0};
            out_h_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            t_q     <= t_d;
            o_q     <= o_d;
            h_q     <= h_d;
            w_q     <= w_d;
            tmp_q   <= tmp_d;
            acc_q   <= acc_d;
            dlo_q   <= dlo_d;
            dh_q    <= dh_d;
            out_o_q <= out_o_d;
            out_h_q <= out_h_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.delta_o1 = out_o_q[0];
    assign bus.delta_o2 = out_o_q[1];
    assign bus.delta_h1 = out_h_q[0];
    assign bus.delta_h2 = out_h_q[1];
    assign bus.delta_h3 = out_h_q[2];
endmodule

// File: tb/tb_backprop_delta.sv
// Directed-vector bench for backprop_delta: table of passes plus reset, abort, handshake and back-to-back sequences.
module tb_backprop_delta;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    backprop_delta_if #(.DWIDTH(32)) bif ();
    backprop_delta #(.DWIDTH(32), .frac(24)) dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct {
        logic [31:0] t1, t2, o1, o2, h1, h2, h3;
        logic [31:0] wa1, wa2, wb1, wb2, wc1, wc2;
        logic [31:0] eo1, eo2, eh1, eh2, eh3;
    } vec_t;

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;
    localparam logic [31:0] QTR  = 32'h0040_0000;

    int checks = 0;
    int errors = 0;
    vec_t vt[5];
    vec_t zero_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bif.t1 = v.t1;  bif.t2 = v.t2;  bif.o1 = v.o1;  bif.o2 = v.o2;
        bif.h1 = v.h1;  bif.h2 = v.h2;  bif.h3 = v.h3;
        bif.wa1 = v.wa1; bif.wa2 = v.wa2; bif.wb1 = v.wb1;
        bif.wb2 = v.wb2; bif.wc1 = v.wc1; bif.wc2 = v.wc2;
    endtask

    task automatic check_deltas(input string tag, input vec_t v);
        check({tag, ".delta_o1"}, bif.delta_o1, v.eo1);
        check({tag, ".delta_o2"}, bif.delta_o2, v.eo2);
        check({tag, ".delta_h1"}, bif.delta_h1, v.eh1);
        check({tag, ".delta_h2"}, bif.delta_h2, v.eh2);
        check({tag, ".delta_h3"}, bif.delta_h3, v.eh3);
    endtask

    // Start pulse sampled at edge N; cycle i is observed at the negedge after edge N+i.
    task automatic do_pass(input vec_t v, input string tag);
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        @(negedge clk);
        drive(v);
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bif.busy) busy_cnt++;
            if (bif.done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (i == 17) check_deltas(tag, v);
        end
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({tag, ".done_cycle"}, 32'(done_at), 32'd17);
        check({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int done_cnt, done_at, last_done, busy_seen;
        zero_v = '{default: 32'h0};
        // nominal: e=0.5, d=0.25 -> 0.125; acc=0.25, g=0.25 -> 0.0625
        vt[0] = '{ONE, ONE, HALF, HALF, HALF, HALF, HALF, ONE, ONE, ONE, ONE, ONE, ONE,
                  32'h0020_0000, 32'h0020_0000, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000};
        // hidden 1 sees +0.125 + 0.125; hidden 2/3 see +0.125 - 0.125 = 0
        vt[1] = '{ONE, 32'h0, HALF, HALF, HALF, HALF, HALF, ONE, 32'hFF00_0000, ONE, ONE, ONE, ONE,
                  32'h0020_0000, 32'hFFE0_0000, 32'h0010_0000, 32'h0, 32'h0};
        // d = 127*(-126) -> min; e*d = (-127)*(-128) -> max; acc max, g=0.25 -> 0x1FFFFFFF
        vt[2] = '{32'h0, ONE, 32'h7F00_0000, HALF, HALF, HALF, HALF, ONE, ONE, ONE, ONE, ONE, ONE,
                  32'h7FFF_FFFF, 32'h0020_0000, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h1FFF_FFFF};
        vt[3] = zero_v;
        // o2=0.25,t2=0.5 -> 0.25*0.1875=3/64; acc=11/64; g=3/16,1/4,3/16
        vt[4] = '{ONE, HALF, HALF, QTR, QTR, HALF, 32'h00C0_0000, ONE, ONE, ONE, ONE, ONE, ONE,
                  32'h0020_0000, 32'h000C_0000, 32'h0008_4000, 32'h000B_0000, 32'h0008_4000};

        rst = 1'b1;
        bif.start = 1'b1;
        drive(vt[0]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d.busy", i), 32'(bif.busy), 32'd0);
            check($sformatf("reset%0d.done", i), 32'(bif.done), 32'd0);
        end
        check_deltas("reset", zero_v);
        rst = 1'b0;
        bif.start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bif.busy || bif.done) busy_seen++;
        end
        check("post_reset_idle", 32'(busy_seen), 32'd0);

        for (int v = 0; v < 5; v++) do_pass(vt[v], $sformatf("vec%0d", v));

        // abort: reset sampled at edge N+8
        @(negedge clk);
        drive(vt[0]);
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy", 32'(bif.busy), 32'd0);
        check_deltas("abort", zero_v);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.done) done_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);
        do_pass(vt[0], "abort_fresh");

        // handshake: inputs change at N+2, extra start at N+5
        @(negedge clk);
        drive(vt[0]);
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        done_cnt = 0;
        done_at = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bif.done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = i;
                    check_deltas("handshake", vt[0]);
                end
            end
            if (i == 2) drive(vt[2]);
            bif.start = (i == 5);
        end
        check("handshake.done_cycle", 32'(done_at), 32'd17);
        check("handshake.done_count", 32'(done_cnt), 32'd1);

        // start held high: passes complete at N+17 and N+34
        @(negedge clk);
        drive(vt[4]);
        bif.start = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        done_at = 0;
        last_done = 0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (bif.done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
                last_done = i;
            end
        end
        bif.start = 1'b0;
        check("b2b.first_done", 32'(done_at), 32'd17);
        check("b2b.last_done", 32'(last_done), 32'd34);
        check("b2b.done_count", 32'(done_cnt), 32'd2);
        check_deltas("b2b", vt[4]);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
